// File: rtl/ctmm_ns_arbiter.sv
// Namespace-memory port arbiter: GC mark/sweep traffic vs. queued G-bit clears.
// A GC read locks the port for the following cycle so a clear cannot split a GC read/write pair.
package ctmm_pkg;
  localparam int PERM_G = 3;

  typedef struct packed {
    logic [15:0] key;
    logic [7:0]  epoch;
    logic [7:0]  perms;
  } golden_token_t;
endpackage

module ctmm_ns_arbiter
  import ctmm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          gc_req,
  input  logic [31:0]                   gc_addr,
  input  logic                          gc_rd_en,
  input  logic                          gc_wr_en,
  input  golden_token_t                 gc_wr_data,
  output logic                          gc_gnt,
  output golden_token_t                 gc_rd_data,
  input  logic                          rst_req_valid,
  input  logic [31:0]                   rst_req_addr,
  output logic                          rst_req_ready,
  output logic [31:0]                   mem_addr,
  output logic                          mem_rd_en,
  output logic                          mem_wr_en,
  output golden_token_t                 mem_wr_data,
  input  golden_token_t                 mem_rd_data,
  output logic                          rst_done,
  output logic [$clog2(FIFO_DEPTH):0]   pending_count,
  output logic [31:0]                   reset_serviced
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GC_LOCK,
    ARB_RST_WRITE
  } arb_state_e;

  arb_state_e            state_q, state_d;
  logic [31:0]           fifo_q [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]         count_q;
  logic [WW-1:0]         wait_q, wait_d;
  logic [31:0]           serviced_q;
  logic [FIFO_DEPTH-1:0] hit;
  logic [31:0]           head;
  logic                  empty, starve, rd_issue, pop, accept, dup, push;
  golden_token_t         rmw_data;

  assign head   = fifo_q[rd_ptr_q];
  assign empty  = (count_q == '0);
  assign starve = (wait_q == WW'(MAX_WAIT)) && !empty;

  // Compare against every occupied slot, the head included even while it is being popped.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_hit
    assign hit[gi] = (CW'(gi) < count_q) &&
                     (fifo_q[rd_ptr_q + AW'(gi)] == rst_req_addr);
  end

  assign rst_req_ready = rst_n && (count_q < CW'(FIFO_DEPTH));
  assign accept        = rst_req_valid && rst_req_ready;
  assign dup           = |hit;
  assign push          = accept && !dup;

  always_comb begin
    rmw_data               = mem_rd_data;
    rmw_data.perms[PERM_G] = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    gc_gnt      = 1'b0;
    mem_addr    = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    rst_done    = 1'b0;
    rd_issue    = 1'b0;
    pop         = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (gc_req && !starve) begin
          gc_gnt      = 1'b1;
          mem_addr    = gc_addr;
          mem_rd_en   = gc_rd_en;
          mem_wr_en   = gc_wr_en;
          mem_wr_data = gc_wr_data;
          if (gc_rd_en) state_d = ARB_GC_LOCK;
        end else if (!empty) begin
          rd_issue  = 1'b1;
          mem_rd_en = 1'b1;
          mem_addr  = head;
          state_d   = ARB_RST_WRITE;
        end
      end
      ARB_GC_LOCK: begin
        gc_gnt      = 1'b1;
        mem_addr    = gc_addr;
        mem_rd_en   = gc_rd_en;
        mem_wr_en   = gc_wr_en;
        mem_wr_data = gc_wr_data;
        state_d     = gc_rd_en ? ARB_GC_LOCK : ARB_IDLE;
      end
      ARB_RST_WRITE: begin
        mem_wr_en   = 1'b1;
        mem_addr    = head;
        mem_wr_data = rmw_data;
        rst_done    = 1'b1;
        pop         = 1'b1;
        state_d     = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (!rst_n) begin
      gc_gnt    = 1'b0;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      rst_done  = 1'b0;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (rd_issue || empty)             wait_d = '0;
    else if (wait_q != WW'(MAX_WAIT))  wait_d = wait_q + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      serviced_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      if (pop) serviced_q <= serviced_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= rst_req_addr;
  end

  assign gc_rd_data     = mem_rd_data;
  assign pending_count  = count_q;
  assign reset_serviced = serviced_q;
endmodule

// File: tb/tb_ctmm_ns_arbiter.sv
// Bench for ctmm_ns_arbiter: queue-based reference model, directed scenarios and random traffic.
module tb_ctmm_ns_arbiter;
  import ctmm_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          gc_req, gc_rd_en, gc_wr_en;
  logic [31:0]   gc_addr;
  golden_token_t gc_wr_data, gc_rd_data;
  logic          gc_gnt;
  logic          rst_req_valid, rst_req_ready;
  logic [31:0]   rst_req_addr;
  logic [31:0]   mem_addr;
  logic          mem_rd_en, mem_wr_en;
  golden_token_t mem_wr_data, mem_rd_data;
  logic          rst_done;
  logic [2:0]    pending_count;
  logic [31:0]   reset_serviced;

  always #5 clk = ~clk;

  ctmm_ns_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .gc_req(gc_req), .gc_addr(gc_addr), .gc_rd_en(gc_rd_en), .gc_wr_en(gc_wr_en),
    .gc_wr_data(gc_wr_data), .gc_gnt(gc_gnt), .gc_rd_data(gc_rd_data),
    .rst_req_valid(rst_req_valid), .rst_req_addr(rst_req_addr), .rst_req_ready(rst_req_ready),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .rst_done(rst_done),
    .pending_count(pending_count), .reset_serviced(reset_serviced)
  );

  function automatic golden_token_t init_val(int i);
    golden_token_t t;
    t.key   = 16'(i * 40503);
    t.epoch = 8'(i ^ 'h5a);
    t.perms = 8'(i * 37 + 11);
    return t;
  endfunction

  // RAM with one-cycle read latency
  golden_token_t ram [256];
  golden_token_t ram_q;
  bit            filled = 1'b0;
  assign mem_rd_data = ram_q;
  always @(posedge clk) begin
    if (!filled) begin
      for (int k = 0; k < 256; k++) ram[k] <= init_val(k);
      filled <= 1'b1;
    end else begin
      if (mem_rd_en) ram_q <= ram[mem_addr[7:0]];
      if (mem_wr_en) ram[mem_addr[7:0]] <= mem_wr_data;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0]   mq [$];
  golden_token_t m_mem [256];
  int            m_wait = 0;
  bit            m_locked = 0, m_rmw = 0, m_rd_valid = 0, m_last_gnt = 0;
  golden_token_t m_rd_exp;
  logic [31:0]   m_serv = 0;

  // Compare every output against the model for the current cycle, then advance the model.
  task automatic tick();
    logic          e_gnt, e_rd, e_wr, e_done, e_rdy, rst_rd, dup, empty, starve;
    logic [31:0]   e_addr;
    golden_token_t e_wd;
    #1;
    e_gnt = 0; e_rd = 0; e_wr = 0; e_done = 0; e_rdy = 0; rst_rd = 0; dup = 0;
    e_addr = '0; e_wd = '0;
    empty  = (mq.size() == 0);
    starve = (m_wait == MAXW) && !empty;
    if (rst_n) begin
      if (m_rmw) begin
        e_wr = 1; e_done = 1; e_addr = mq[0];
        e_wd = m_mem[mq[0][7:0]];
        e_wd.perms[PERM_G] = 1'b0;
      end else if (m_locked || (gc_req && !starve)) begin
        e_gnt = 1; e_addr = gc_addr; e_rd = gc_rd_en; e_wr = gc_wr_en; e_wd = gc_wr_data;
      end else if (!empty) begin
        e_rd = 1; e_addr = mq[0]; rst_rd = 1;
      end
      e_rdy = (mq.size() < DEPTH);
    end
    check("gc_gnt", 64'(gc_gnt), 64'(e_gnt));
    check("mem_rd_en", 64'(mem_rd_en), 64'(e_rd));
    check("mem_wr_en", 64'(mem_wr_en), 64'(e_wr));
    check("rst_done", 64'(rst_done), 64'(e_done));
    check("rst_req_ready", 64'(rst_req_ready), 64'(e_rdy));
    check("pending_count", 64'(pending_count), 64'(mq.size()));
    check("reset_serviced", 64'(reset_serviced), 64'(m_serv));
    if (rst_n) check("mem_addr", 64'(mem_addr), 64'(e_addr));
    if (e_wr) check("mem_wr_data", 64'(mem_wr_data), 64'(e_wd));
    if (m_rd_valid) check("gc_rd_data", 64'(gc_rd_data), 64'(m_rd_exp));

    if (!rst_n) begin
      mq.delete();
      m_wait = 0; m_locked = 0; m_rmw = 0; m_rd_valid = 0; m_serv = 0; m_last_gnt = 0;
    end else begin
      m_rd_valid = e_gnt && e_rd;
      if (m_rd_valid) m_rd_exp = m_mem[e_addr[7:0]];
      if (e_wr) m_mem[e_addr[7:0]] = e_wd;
      if (rst_req_valid && e_rdy) foreach (mq[k]) if (mq[k] == rst_req_addr) dup = 1;
      if (m_rmw) begin
        void'(mq.pop_front());
        m_serv = m_serv + 32'd1;
      end
      if (rst_req_valid && e_rdy && !dup) mq.push_back(rst_req_addr);
      if (rst_rd || empty) m_wait = 0;
      else if (m_wait < MAXW) m_wait++;
      m_locked   = e_gnt && e_rd;
      m_rmw      = rst_rd;
      m_last_gnt = e_gnt;
    end
  endtask

  task automatic idle_inputs();
    gc_req = 0; gc_rd_en = 0; gc_wr_en = 0; gc_addr = '0; gc_wr_data = '0;
    rst_req_valid = 0; rst_req_addr = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    golden_token_t t;
    logic [31:0] push_addr [7] = '{32'h20, 32'h21, 32'h22, 32'h21, 32'h23, 32'h30, 32'h21};
    logic        push_rdy  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int          push_cnt  [7] = '{0, 1, 2, 3, 3, 4, 4};

    for (int k = 0; k < 256; k++) m_mem[k] = init_val(k);
    rst_n = 0;
    idle_inputs();
    step();
    repeat (3) begin
      gc_req = 1; gc_rd_en = 1; rst_req_valid = 1;
      tick();
      check("rst_force_gnt", 64'(gc_gnt), 64'd0);
      step();
    end
    rst_n = 1;
    idle_inputs();
    tick();
    check("rst_pending", 64'(pending_count), 64'd0);
    check("rst_serviced", 64'(reset_serviced), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    step();

    // Single reset at 0x40, no GC traffic
    rst_req_valid = 1; rst_req_addr = 32'h40;
    tick(); check("s1_ready", 64'(rst_req_ready), 64'd1); step();
    idle_inputs();
    tick(); check("s1_rd", 64'(mem_rd_en), 64'd1); check("s1_rd_addr", 64'(mem_addr), 64'h40); step();
    t = init_val(32'h40); t.perms[PERM_G] = 1'b0;
    tick(); check("s1_wr", 64'(mem_wr_en), 64'd1); check("s1_wdata", 64'(mem_wr_data), 64'(t));
    check("s1_done", 64'(rst_done), 64'd1); step();
    tick(); check("s1_serviced", 64'(reset_serviced), 64'd1); check("s1_done_off", 64'(rst_done), 64'd0); step();

    // GC read/write of 0x10 racing a reset of 0x10
    gc_req = 1; gc_rd_en = 1; gc_addr = 32'h10; rst_req_valid = 1; rst_req_addr = 32'h10;
    tick(); check("s2_gnt_rd", 64'(gc_gnt), 64'd1); step();
    rst_req_valid = 0; gc_rd_en = 0; gc_wr_en = 1; gc_wr_data = '{16'hbeef, 8'h01, 8'hff};
    tick(); check("s2_lock_wr", 64'(mem_wr_en), 64'd1); check("s2_lock_nord", 64'(mem_rd_en), 64'd0);
    check("s2_rd_data", 64'(gc_rd_data), 64'(init_val(32'h10))); step();
    idle_inputs();
    tick(); check("s2_rst_rd", 64'(mem_rd_en), 64'd1); check("s2_rst_addr", 64'(mem_addr), 64'h10); step();
    tick(); check("s2_final", 64'(mem_wr_data), 64'h0000_beef_01f7); step();

    // Continuous GC writes: starvation forces the reset read on cycle 9
    for (int i = 0; i < 12; i++) begin
      gc_req = 1; gc_wr_en = 1; gc_addr = 32'h80; gc_wr_data = '{16'h1234, 8'h55, 8'haa};
      rst_req_valid = (i == 0); rst_req_addr = 32'h44;
      tick();
      check("s3_gnt", 64'(gc_gnt), (i == 9 || i == 10) ? 64'd0 : 64'd1);
      check("s3_rst_rd", 64'(mem_rd_en), (i == 9) ? 64'd1 : 64'd0);
      step();
    end
    idle_inputs();

    // Fill while the GC keeps the port locked, including a coalesced duplicate
    for (int i = 0; i < 7; i++) begin
      gc_req = 1; gc_rd_en = 1; gc_addr = 32'h90;
      rst_req_valid = 1; rst_req_addr = push_addr[i];
      tick();
      check("s4_ready", 64'(rst_req_ready), 64'(push_rdy[i]));
      check("s4_count", 64'(pending_count), 64'(push_cnt[i]));
      step();
    end
    idle_inputs();
    repeat (14) begin tick(); step(); end
    check("s4_drained", 64'(pending_count), 64'd0);

    // Reset asserted during the write half of an RMW
    rst_req_valid = 1; rst_req_addr = 32'h45;
    tick(); step();
    idle_inputs();
    tick(); check("s5_rd", 64'(mem_rd_en), 64'd1); step();
    rst_n = 0; gc_req = 1; gc_rd_en = 1; rst_req_valid = 1; rst_req_addr = 32'h46;
    tick();
    check("s5_no_wr", 64'(mem_wr_en), 64'd0); check("s5_no_done", 64'(rst_done), 64'd0);
    check("s5_no_gnt", 64'(gc_gnt), 64'd0); check("s5_no_rdy", 64'(rst_req_ready), 64'd0);
    step();
    rst_n = 1; idle_inputs();
    tick(); check("s5_pending", 64'(pending_count), 64'd0); check("s5_serviced", 64'(reset_serviced), 64'd0);
    step();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (!(gc_req && !m_last_gnt)) begin
        gc_req = ($urandom_range(0, 2) == 0);
        gc_rd_en = gc_req && $urandom_range(0, 1) == 1;
        gc_wr_en = gc_req && !gc_rd_en;
        gc_addr = 32'h40 + 32'($urandom_range(0, 7));
        gc_wr_data = $urandom;
      end
      rst_req_valid = ($urandom_range(0, 2) == 0);
      rst_req_addr = 32'h40 + 32'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
